// File: rtl/mem_arbiter.sv
// Two-requester arbiter for a shared fixed-latency single-port memory.
// Instruction fetch and data load/store alternate priority under contention.
module mem_arbiter #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int LATENCY = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ack,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam logic [3:0] LAT_C = 4'(LATENCY);

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              last_q, last_d;
    logic              owner_q, owner_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_wr_q, mem_wr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              grant_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            last_q      <= 1'b0;
            owner_q     <= 1'b0;
            mem_addr_q  <= '0;
            mem_wr_q    <= 1'b0;
            mem_wdata_q <= '0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_q      <= last_d;
            owner_q     <= owner_d;
            mem_addr_q  <= mem_addr_d;
            mem_wr_q    <= mem_wr_d;
            mem_wdata_q <= mem_wdata_d;
            i_rdata_q   <= i_rdata_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        last_d      = last_q;
        owner_d     = owner_q;
        mem_addr_d  = mem_addr_q;
        mem_wr_d    = mem_wr_q;
        mem_wdata_d = mem_wdata_q;
        i_rdata_d   = i_rdata_q;
        d_rdata_d   = d_rdata_q;
        grant_d     = 1'b0;

        case (state_q)
            IDLE: begin
                // last_q=0 means instr won last time, so data wins a tie
                grant_d = d_req && (!i_req || !last_q);
                if (i_req || d_req) begin
                    owner_d     = grant_d;
                    last_d      = grant_d;
                    mem_addr_d  = grant_d ? d_addr : i_addr;
                    mem_wr_d    = grant_d && d_we;
                    mem_wdata_d = grant_d ? d_wdata : '0;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = LAT_C;
                state_d = WAIT;
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    if (!mem_wr_q) begin
                        if (owner_q) d_rdata_d = mem_rdata;
                        else         i_rdata_d = mem_rdata;
                    end
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign mem_en    = (state_q == ISSUE);
    assign i_ack     = (state_q == RESP) && !owner_q;
    assign d_ack     = (state_q == RESP) && owner_q;
    assign busy      = (state_q != IDLE);
    assign mem_addr  = mem_addr_q;
    assign mem_wr    = mem_wr_q;
    assign mem_wdata = mem_wdata_q;
    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a behavioural fixed-latency memory plus
// requesters that advance to their next queued transaction on each ack.
module tb_mem_arbiter;

    localparam int AW  = 16;
    localparam int DW  = 16;
    localparam int LAT = 4;

    typedef struct {
        logic [AW-1:0] addr;
        logic          we;
        logic [DW-1:0] wdata;
    } txn_t;

    typedef struct {
        bit            is_d;
        logic [DW-1:0] rdata;
        int            cyc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_req, d_req, d_we;
    logic [AW-1:0] i_addr, d_addr;
    logic [DW-1:0] d_wdata;
    logic          i_ack, d_ack, mem_en, mem_wr, busy;
    logic [DW-1:0] i_rdata, d_rdata, mem_wdata, mem_rdata;
    logic [AW-1:0] mem_addr;

    txn_t          iq[$];
    txn_t          dq[$];
    exp_t          sb[$];
    exp_t          e_cur;
    logic [DW-1:0] mem [0:65535];
    logic [DW-1:0] exp_i, exp_d;
    logic [DW-1:0] m_rd;
    int            m_dly;
    int            cyc = 0;
    int            n_chk = 0;
    int            n_bad = 0;
    int            t0;
    int            en_seen;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LATENCY(LAT)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got=%0h want=%0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    // Memory: data for an access started at mem_en is valid exactly LAT cycles later,
    // and the complement is driven in every other cycle.
    initial begin
        m_dly     = 0;
        m_rd      = '0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (mem_en) begin
                m_rd = mem[mem_addr];
                if (mem_wr) mem[mem_addr] = mem_wdata;
                m_dly     = LAT;
                mem_rdata = ~m_rd;
            end else if (m_dly == 1) begin
                mem_rdata = m_rd;
                m_dly     = 0;
            end else begin
                mem_rdata = ~m_rd;
                if (m_dly > 1) m_dly--;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic load_i();
        txn_t t;
        if (iq.size() > 0) begin
            t      = iq.pop_front();
            i_addr = t.addr;
            i_req  = 1'b1;
        end else begin
            i_req = 1'b0;
        end
    endtask

    task automatic load_d();
        txn_t t;
        if (dq.size() > 0) begin
            t       = dq.pop_front();
            d_addr  = t.addr;
            d_we    = t.we;
            d_wdata = t.wdata;
            d_req   = 1'b1;
        end else begin
            d_req = 1'b0;
        end
    endtask

    // Ack handling at the falling edge, then step to just after the next rising edge.
    task automatic tick();
        @(negedge clk);
        if (i_ack && d_ack) chk("dual_ack", 32'({i_ack, d_ack}), 32'h1);
        if (i_ack || d_ack) begin
            if (sb.size() == 0) begin
                chk("spurious_ack", 32'({i_ack, d_ack}), 32'h0);
            end else begin
                e_cur = sb.pop_front();
                chk("ack_who", 32'(d_ack), 32'(e_cur.is_d));
                chk("ack_cyc", 32'(cyc), 32'(e_cur.cyc));
                if (e_cur.is_d) begin
                    chk("d_rdata", 32'(d_rdata), 32'(e_cur.rdata));
                    chk("i_rdata_hold", 32'(i_rdata), 32'(exp_i));
                    exp_d = e_cur.rdata;
                end else begin
                    chk("i_rdata", 32'(i_rdata), 32'(e_cur.rdata));
                    chk("d_rdata_hold", 32'(d_rdata), 32'(exp_d));
                    exp_i = e_cur.rdata;
                end
            end
            if (i_ack) load_i();
            if (d_ack) load_d();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((sb.size() > 0 || busy || i_req || d_req) && n < 200) begin
            tick();
            n++;
        end
        chk({tag, "_pending"}, 32'(sb.size()), 32'h0);
        chk({tag, "_idle"}, 32'(busy), 32'h0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst   = 1'b0;
        exp_i = '0;
        exp_d = '0;
    endtask

    initial begin
        rst     = 1'b1;
        i_req   = 1'b0;
        d_req   = 1'b0;
        d_we    = 1'b0;
        i_addr  = '0;
        d_addr  = '0;
        d_wdata = '0;
        exp_i   = '0;
        exp_d   = '0;
        for (int i = 0; i < 65536; i++) mem[i] = 16'(i) ^ 16'h5A5A;
        mem[16'h0010] = 16'hA5A5;
        mem[16'h0040] = 16'h0F0F;
        mem[16'h0300] = 16'hBEEF;

        // reset state
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_ctl", 32'({i_ack, d_ack, mem_en, mem_wr, busy}), 32'h0);
        chk("rst_addr", 32'(mem_addr), 32'h0);
        chk("rst_wdata", 32'(mem_wdata), 32'h0);
        chk("rst_rdata", {i_rdata, d_rdata}, 32'h0);
        rst     = 1'b0;
        en_seen = 0;
        repeat (10) begin
            tick();
            if (mem_en) en_seen++;
        end
        chk("idle_mem_en", 32'(en_seen), 32'h0);
        chk("idle_busy", 32'(busy), 32'h0);

        // instruction read
        t0 = cyc;
        iq.push_back('{16'h0010, 1'b0, 16'h0000});
        load_i();
        sb.push_back('{1'b0, 16'hA5A5, t0 + 6});
        tick();
        chk("i_issue_en", 32'(mem_en), 32'h1);
        chk("i_issue_wr", 32'(mem_wr), 32'h0);
        chk("i_issue_addr", 32'(mem_addr), 32'h0010);
        drain("i_rd");

        // data write; d_rdata must stay at its reset value
        t0 = cyc;
        dq.push_back('{16'h0200, 1'b1, 16'h1234});
        load_d();
        sb.push_back('{1'b1, 16'h0000, t0 + 6});
        tick();
        chk("d_issue_en", 32'(mem_en), 32'h1);
        chk("d_issue_wr", 32'(mem_wr), 32'h1);
        chk("d_issue_addr", 32'(mem_addr), 32'h0200);
        chk("d_issue_wdata", 32'(mem_wdata), 32'h1234);
        drain("d_wr");
        chk("d_wr_mem", 32'(mem[16'h0200]), 32'h1234);

        // contention straight after reset: data first
        do_reset();
        t0 = cyc;
        dq.push_back('{16'h0300, 1'b0, 16'h0000});
        iq.push_back('{16'h0040, 1'b0, 16'h0000});
        load_d();
        load_i();
        sb.push_back('{1'b1, 16'hBEEF, t0 + 6});
        sb.push_back('{1'b0, 16'h0F0F, t0 + 13});
        drain("cont1");

        // continuous contention, last grant was instr: D I D I
        t0 = cyc;
        dq.push_back('{16'h0200, 1'b0, 16'h0000});
        dq.push_back('{16'h0300, 1'b1, 16'h7777});
        iq.push_back('{16'h0010, 1'b0, 16'h0000});
        iq.push_back('{16'h0040, 1'b0, 16'h0000});
        load_d();
        load_i();
        sb.push_back('{1'b1, 16'h1234, t0 + 6});
        sb.push_back('{1'b0, 16'hA5A5, t0 + 13});
        sb.push_back('{1'b1, 16'h1234, t0 + 20});
        sb.push_back('{1'b0, 16'h0F0F, t0 + 27});
        drain("cont4");
        chk("cont4_wr_mem", 32'(mem[16'h0300]), 32'h7777);

        // asynchronous reset during WAIT of a data read
        t0 = cyc;
        dq.push_back('{16'h0300, 1'b0, 16'h0000});
        load_d();
        tick();
        tick();
        tick();
        chk("mid_busy_pre", 32'(busy), 32'h1);
        #2;
        rst   = 1'b1;
        d_req = 1'b0;
        #1;
        chk("mid_rst_ctl", 32'({i_ack, d_ack, mem_en, mem_wr, busy}), 32'h0);
        chk("mid_rst_addr", 32'(mem_addr), 32'h0);
        chk("mid_rst_rdata", {i_rdata, d_rdata}, 32'h0);
        exp_i = '0;
        exp_d = '0;
        tick();
        #1;
        rst = 1'b0;
        t0  = cyc;
        iq.push_back('{16'h0010, 1'b0, 16'h0000});
        load_i();
        sb.push_back('{1'b0, 16'hA5A5, t0 + 6});
        drain("mid_rst");

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbitrates one shared, fixed-latency, single-ported memory between the instruction-fetch requester and the data-access (load/store) requester. Sits between the fetch/load-store stages and a unified memory. Each requester issues single-word transactions through a req/ack handshake. The block sequences each memory access with a small FSM and alternates priority when both requesters contend.

## Interface
- ADDR_W, 16, address width
- DATA_W, 16, data word width
- LATENCY, 4, memory cycles from the `mem_en` cycle to the `mem_rdata`-valid cycle; legal range 1..15
- clk  input  1  system clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- i_req  input  1  instruction read request, level
- i_addr  input  ADDR_W  instruction address
- i_ack  output  1  one-cycle completion pulse for instruction read
- i_rdata  output  DATA_W  instruction read data, registered
- d_req  input  1  data request, level
- d_we  input  1  1 = write, 0 = read
- d_addr  input  ADDR_W  data address
- d_wdata  input  DATA_W  write data
- d_ack  output  1  one-cycle completion pulse for data access
- d_rdata  output  DATA_W  data read result, registered
- mem_en  output  1  one-cycle access strobe to memory
- mem_wr  output  1  access is a write
- mem_addr  output  ADDR_W  memory address
- mem_wdata  output  DATA_W  memory write data
- mem_rdata  input  DATA_W  memory read data, valid exactly LATENCY cycles after the `mem_en` cycle
- busy  output  1  high whenever the state is not IDLE

## Operation
- States: IDLE, ISSUE, WAIT, RESP. 4-bit down-counter `cnt`. 1-bit `last` records the most recent grant (0 = instr, 1 = data). 1-bit `owner`.
- IDLE: if any req is high, grant and go to ISSUE.
  - If both are high, the requester that did not win last time gets the grant.
  - On grant, latch owner, address, write flag (instr always read) and write data into the `mem_*` registers. Update `last`.
- ISSUE: `mem_en`=1 for exactly this cycle. Load `cnt`=LATENCY. Go to WAIT.
- WAIT: decrement `cnt` each cycle.
  - In the cycle `cnt`==1, `mem_rdata` is valid. If the owner is reading, capture it at the end of the cycle into the owner's rdata register.
  - Then go to RESP.
- RESP: assert the owner's ack only, for one cycle. Go to IDLE.
- Writes use the identical sequence. `d_rdata` is not updated on a write.
- Each rdata register changes only on its own read completion and holds otherwise.
- `mem_addr`, `mem_wr` and `mem_wdata` are held stable from ISSUE through RESP.
- Requester rules:
  - Hold req, addr, we and wdata stable from assertion until ack.
  - Req still high in the cycle after ack is treated as a new request.
- Inputs are sampled only in IDLE. Req changes while busy are ignored until return to IDLE.
- Reset (asynchronous, any time, including mid-transaction):
  - State → IDLE, `cnt`=0, `last`=0 (so data wins the first contention).
  - All outputs, including both rdata registers and `mem_*`, → 0.
  - The in-flight transaction is abandoned; no ack is produced.

## Timing
- Req sampled high in IDLE at cycle 0:
  - ISSUE (`mem_en`) in cycle 1.
  - WAIT in cycles 2..LATENCY+1; rdata captured at the end of cycle LATENCY+1.
  - Ack in cycle LATENCY+2.
  - IDLE in cycle LATENCY+3.
- Req-to-ack latency is LATENCY+2 cycles; minimum request spacing is LATENCY+3.
- With LATENCY=1, WAIT lasts one cycle.
- Ack and the updated rdata become visible in the same cycle.
- All outputs are registered or decoded from state; there is no combinational path from req to any output.
- Contention: the loser stays pending and is granted in the next IDLE cycle (LATENCY+3 after the first grant).

## Test plan
- Reset:
  - Stimulus: hold rst=1, then release.
  - Required: every output is 0 and busy=0; with no req for 10 cycles, `mem_en` stays 0.
- Instruction read, LATENCY=4:
  - Stimulus: i_req=1, i_addr=0x0010 at cycle 0; memory returns 0xA5A5 in cycle 5.
  - Required: `mem_en`=1, `mem_wr`=0, `mem_addr`=0x0010 in cycle 1; i_ack=1 with i_rdata=0xA5A5 in cycle 6; d_ack=0 throughout.
- Data write:
  - Stimulus: d_req=1, d_we=1, d_addr=0x0200, d_wdata=0x1234.
  - Required: cycle 1 shows `mem_en`=1, `mem_wr`=1, `mem_wdata`=0x1234; d_ack in cycle 6; d_rdata unchanged.
- Contention after reset:
  - Stimulus: i_req and d_req (read, 0x0300) both high at cycle 0, each dropping req the cycle after its own ack.
  - Required: data is served first (d_ack cycle 6); instruction is granted in cycle 7 with i_ack in cycle 13.
- Continuous contention:
  - Stimulus: both reqs held high for 4 transactions.
  - Required: grants alternate D, I, D, I; acks in cycles 6, 13, 20, 27.
- Reset mid-transaction:
  - Stimulus: assert rst asynchronously during WAIT in cycle 3 of a data read, release in cycle 4, then hold i_req high.
  - Required: outputs are 0 immediately; no d_ack is produced; the instruction read completes normally LATENCY+2 cycles after being sampled.
